// File: rtl/gpio_link_rx_pkg.sv
// Shared game-side types for the remote-player GPIO link.
// move_dir_t is also consumed by draw_player_ctl.
package gpio_link_rx_pkg;

  typedef enum logic [1:0] {
    MOVE_NONE  = 2'b00,
    MOVE_LEFT  = 2'b01,
    MOVE_RIGHT = 2'b10
  } move_dir_t;

  // Both buttons held cancel each other out, as does neither.
  function automatic move_dir_t dir_of(input logic left, input logic right);
    case ({left, right})
      2'b10:   return MOVE_LEFT;
      2'b01:   return MOVE_RIGHT;
      default: return MOVE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_link_rx_if.sv
// Pin-side and player-control-side signals of the GPIO link receiver.
// master: whoever drives the raw lines and v_tick; slave: the receiver.
interface gpio_link_rx_if;
  import gpio_link_rx_pkg::*;

  logic      v_tick;
  logic      gpio_left;
  logic      gpio_right;
  logic      left_lvl;
  logic      right_lvl;
  logic      left_press;
  logic      right_press;
  move_dir_t move_dir;
  logic      frame_stb;

  modport master (
    output v_tick, gpio_left, gpio_right,
    input  left_lvl, right_lvl, left_press, right_press, move_dir, frame_stb
  );

  modport slave (
    input  v_tick, gpio_left, gpio_right,
    output left_lvl, right_lvl, left_press, right_press, move_dir, frame_stb
  );

endinterface

// File: rtl/gpio_link_rx_debounce.sv
// One GPIO line: 2-flop synchroniser followed by a debounce FSM.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive
// synchronised samples agree; press pulses on accepted 0->1 only.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 40000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic lvl,
  output logic press
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } db_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             s1, s2;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             press_nxt;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  // FSM state, stability counter and the registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE_LO;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  // Saturating increment; the counter never wraps back into range.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // Next-state: any disagreeing sample aborts a wait and clears the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    case (state)
      IDLE_LO: if (s2) begin
        state_nxt = WAIT_HI;
        cnt_nxt   = CNT_ONE;
      end
      WAIT_HI: begin
        if (!s2) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      IDLE_HI: if (!s2) begin
        state_nxt = WAIT_LO;
        cnt_nxt   = CNT_ONE;
      end
      WAIT_LO: begin
        if (s2) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Level is high while settled high or while a release is still unproven.
  assign lvl = (state == IDLE_HI) || (state == WAIT_LO);

endmodule

// File: rtl/gpio_link_rx.sv
// Receive-side conditioner for the remote player's two button lines.
// Debounces each line and latches one movement command per VGA frame.
module gpio_link_rx
  import gpio_link_rx_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 40000,
  parameter int CNT_W           = 16
) (
  input  logic           clk,
  input  logic           rst,
  gpio_link_rx_if.slave  bus
);

  logic      left_lvl, right_lvl;
  logic      left_press, right_press;
  logic      v_s1, v_s2, v_prev;
  logic      frame_rise;
  move_dir_t move_dir;
  logic      frame_stb;

  gpio_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_left (
    .clk   (clk),
    .rst   (rst),
    .pin   (bus.gpio_left),
    .lvl   (left_lvl),
    .press (left_press)
  );

  gpio_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_right (
    .clk   (clk),
    .rst   (rst),
    .pin   (bus.gpio_right),
    .lvl   (right_lvl),
    .press (right_press)
  );

  // Synchronise vsync and keep its previous value for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s1   <= 1'b0;
      v_s2   <= 1'b0;
      v_prev <= 1'b0;
    end else begin
      v_s1   <= bus.v_tick;
      v_s2   <= v_s1;
      v_prev <= v_s2;
    end
  end

  assign frame_rise = v_s2 & ~v_prev;

  // Latch the command once per frame from the registered (pre-change) levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_dir  <= MOVE_NONE;
      frame_stb <= 1'b0;
    end else begin
      frame_stb <= frame_rise;
      if (frame_rise) move_dir <= dir_of(left_lvl, right_lvl);
    end
  end

  assign bus.left_lvl    = left_lvl;
  assign bus.right_lvl   = right_lvl;
  assign bus.left_press  = left_press;
  assign bus.right_press = right_press;
  assign bus.move_dir    = move_dir;
  assign bus.frame_stb   = frame_stb;

endmodule

// File: tb/tb_gpio_link_rx.sv
// Scoreboard bench for gpio_link_rx with DEBOUNCE_CYCLES=8: directed
// scenarios followed by randomized line/vsync activity and a mid-run reset.
module tb_gpio_link_rx;
  import gpio_link_rx_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gpio_link_rx_if bus();

  gpio_link_rx #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ll;
    logic       rl;
    logic       lp;
    logic       rp;
    logic [1:0] md;
    logic       fs;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 0;

  // Reference model: pin/vsync sample history plus "consecutive
  // disagreeing samples" per line.
  bit       hl[2], hr[2], vh[3];
  bit       m_ll, m_rl;
  int       run_l, run_r;
  logic [1:0] m_md;

  function automatic void model_reset();
    hl = '{0, 0}; hr = '{0, 0}; vh = '{0, 0, 0};
    m_ll = 0; m_rl = 0; run_l = 0; run_r = 0; m_md = 2'b00;
  endfunction

  // A level flips once D consecutive synchronised samples disagree with it.
  function automatic void db(input bit s2, input bit lvl_i, input int run_i,
                             output bit lvl_o, output int run_o, output logic press);
    lvl_o = lvl_i; run_o = 0; press = 1'b0;
    if (s2 != lvl_i) begin
      run_o = run_i + 1;
      if (run_o == D) begin
        lvl_o = ~lvl_i;
        run_o = 0;
        press = lvl_o;
      end
    end
  endfunction

  // Drive inputs for the next rising edge and queue the expected outputs.
  task automatic step(input bit l, input bit r, input bit v, input bit rs);
    obs_t e;
    bit   nl, nr, rise;
    int   nrl, nrr;
    @(negedge clk);
    rst            = rs;
    bus.gpio_left  = l;
    bus.gpio_right = r;
    bus.v_tick     = v;
    e = '0;
    if (rs) begin
      model_reset();
    end else begin
      rise = vh[1] && !vh[2];
      if (rise) begin
        if (m_ll && !m_rl)      m_md = 2'b01;
        else if (!m_ll && m_rl) m_md = 2'b10;
        else                    m_md = 2'b00;
      end
      e.fs = rise;
      e.md = m_md;
      db(hl[1], m_ll, run_l, nl, nrl, e.lp);
      db(hr[1], m_rl, run_r, nr, nrr, e.rp);
      m_ll = nl; run_l = nrl; m_rl = nr; run_r = nrr;
      e.ll = m_ll;
      e.rl = m_rl;
      hl[1] = hl[0]; hl[0] = l;
      hr[1] = hr[0]; hr[0] = r;
      vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = v;
    end
    exp_q.push_back(e);
    mon_en = 1;
  endtask

  function automatic obs_t sample();
    obs_t g;
    g = {bus.left_lvl, bus.right_lvl, bus.left_press, bus.right_press,
         bus.move_dir, bus.frame_stb};
    return g;
  endfunction

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic do_reset();
    obs_t g;
    @(negedge clk);
    rst = 1'b1;
    #1;
    g = sample();
    checks++;
    if (g !== obs_t'(0)) begin
      errors++;
      $display("FAIL async_reset t=%0t: got %b, expected %b", $time, g, obs_t'(0));
    end
    model_reset();
    exp_q.push_back('0);
  endtask

  // Monitor: compare every DUT cycle against the queued expectation.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard cycle %0d: got no expectation, expected one queued", cyc);
        end else begin
          e = exp_q.pop_front();
          g = sample();
          checks++;
          if (g !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got ll/rl/lp/rp/md/fs=%b, expected %b", cyc, g, e);
          end
        end
      end
    end
  end

  bit sl, sr, sv;
  int hold_l, hold_r, vcnt;

  initial begin
    bus.gpio_left = 0; bus.gpio_right = 0; bus.v_tick = 0;
    model_reset();
    repeat (3) step(0, 0, 0, 1);
    // clean left press and a frame -> MOVE_LEFT
    repeat (12) step(1, 0, 0, 0);
    repeat (4)  step(1, 0, 1, 0);
    repeat (6)  step(1, 0, 0, 0);
    // reset mid right count with left high and MOVE_LEFT latched
    repeat (5)  step(1, 1, 0, 0);
    do_reset();
    repeat (2)  step(1, 0, 0, 1);
    repeat (12) step(1, 0, 0, 0);
    // right glitch shorter than D
    repeat (5)  step(1, 1, 0, 0);
    repeat (10) step(1, 0, 0, 0);
    // release left, then bouncing press
    repeat (12) step(0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(((i / 3) % 2) == 0, 0, 0, 0);
    repeat (14) step(1, 0, 0, 0);
    // frame with left, release mid-frame, next frame -> NONE
    repeat (3)  step(1, 0, 1, 0);
    repeat (12) step(0, 0, 0, 0);
    repeat (3)  step(0, 0, 1, 0);
    repeat (5)  step(0, 0, 0, 0);
    // both pressed -> NONE, right released -> LEFT
    repeat (12) step(1, 1, 0, 0);
    repeat (3)  step(1, 1, 1, 0);
    repeat (4)  step(1, 1, 0, 0);
    repeat (12) step(1, 0, 0, 0);
    repeat (3)  step(1, 0, 1, 0);
    repeat (5)  step(1, 0, 0, 0);
    // randomized activity with holds around the debounce threshold
    sl = 1; sr = 0; sv = 0; hold_l = 0; hold_r = 0; vcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_l == 0) begin sl = 1'($urandom_range(0, 1)); hold_l = $urandom_range(1, 14); end
      if (hold_r == 0) begin sr = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 14); end
      if (vcnt == 0) begin
        sv = ~sv;
        vcnt = sv ? $urandom_range(1, 4) : $urandom_range(5, 40);
      end
      hold_l--; hold_r--; vcnt--;
      if (i == 1500) do_reset();
      else           step(sl, sr, sv, (i > 1500) && (i < 1503));
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
